// File: rtl/nn_io_pkg.sv
// nn_io_pkg
// Shared definitions for the network input loader: default frame geometry
// (784 Q8.8 words), default synchronizer depth and the receiver FSM states.
// No ports; imported by the loader interface, the synchronizer and the top.
package nn_io_pkg;

  localparam int DEFAULT_NUM_WORDS   = 784;
  localparam int DEFAULT_DATA_WIDTH  = 16;
  localparam int DEFAULT_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECEIVE = 2'd1,
    CHECK   = 2'd2
  } loader_state_t;

endpackage

// File: rtl/serial_frame_loader_if.sv
// serial_frame_loader_if
// Bundles the serial pins, the consumer handshake and the status outputs of
// serial_frame_loader.
//   serialClock, serialData, serialSelect_n : asynchronous serial link
//   frameTaken                             : consumer acknowledge pulse
//   dataOut, frameValid                    : committed frame and its flag
//   busy, frameError, overrun, wordCount   : receiver status
// Modports: master = frame source / consumer side, slave = the loader.
interface serial_frame_loader_if
  import nn_io_pkg::*;
#(
  parameter int NUM_WORDS  = DEFAULT_NUM_WORDS,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

  localparam int COUNT_WIDTH = $clog2(NUM_WORDS + 1);

  logic                            serialClock;
  logic                            serialData;
  logic                            serialSelect_n;
  logic                            frameTaken;
  logic [NUM_WORDS*DATA_WIDTH-1:0] dataOut;
  logic                            frameValid;
  logic                            busy;
  logic                            frameError;
  logic                            overrun;
  logic [COUNT_WIDTH-1:0]          wordCount;

  modport master (
    output serialClock, serialData, serialSelect_n, frameTaken,
    input  dataOut, frameValid, busy, frameError, overrun, wordCount
  );

  modport slave (
    input  serialClock, serialData, serialSelect_n, frameTaken,
    output dataOut, frameValid, busy, frameError, overrun, wordCount
  );

endinterface

// File: rtl/sync_edge_detect.sv
// sync_edge_detect
// Brings one asynchronous input into the CLOCK_50 domain through a
// SYNC_STAGES flop chain, then compares the last stage with a history flop
// to produce single-cycle edge pulses.
//   CLOCK_50 : system clock        reset : synchronous, active-high
//   async_in : asynchronous input  level : synchronized level
//   rise     : one-cycle pulse on a synchronized 0->1 transition
//   fall     : one-cycle pulse on a synchronized 1->0 transition
module sync_edge_detect
  import nn_io_pkg::*;
#(
  parameter int   SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter logic IDLE_LEVEL  = 1'b0
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   history;

  // Reset to the line's idle level so that leaving reset never looks like an edge.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync_chain <= {SYNC_STAGES{IDLE_LEVEL}};
      history    <= IDLE_LEVEL;
    end else begin
      sync_chain <= {sync_chain[SYNC_STAGES-2:0], async_in};
      history    <= sync_chain[SYNC_STAGES-1];
    end
  end

  assign level = sync_chain[SYNC_STAGES-1];
  assign rise  = level & ~history;
  assign fall  = ~level & history;

endmodule

// File: rtl/serial_frame_loader.sv
// serial_frame_loader
// Receives a frame of NUM_WORDS words, DATA_WIDTH bits each, MSB first, over
// an asynchronous SPI-like link (serialClock / serialData / serialSelect_n).
// Words collect in a shadow buffer; when select rises with exactly
// NUM_WORDS complete words the shadow is committed to dataOut and frameValid
// is raised, otherwise frameError is flagged and dataOut is left alone.
//   CLOCK_50 : system clock, rising edge
//   reset    : synchronous, active-high
//   bus      : serial_frame_loader_if slave (serial pins, frameTaken,
//              dataOut, frameValid, busy, frameError, overrun, wordCount)
module serial_frame_loader
  import nn_io_pkg::*;
#(
  parameter int NUM_WORDS   = DEFAULT_NUM_WORDS,
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input logic                 CLOCK_50,
  input logic                 reset,
  serial_frame_loader_if.slave bus
);

  localparam int COUNT_WIDTH = $clog2(NUM_WORDS + 1);
  localparam int BIT_WIDTH   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [COUNT_WIDTH-1:0] FULL_COUNT = COUNT_WIDTH'(NUM_WORDS);
  localparam logic [BIT_WIDTH-1:0]   LAST_BIT   = BIT_WIDTH'(DATA_WIDTH - 1);

  logic clock_level, clock_rise, clock_fall;
  logic select_level, select_rise, select_fall;
  logic unused_sync;

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES),
    .IDLE_LEVEL  (1'b0)
  ) clock_sync (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .async_in (bus.serialClock),
    .level    (clock_level),
    .rise     (clock_rise),
    .fall     (clock_fall)
  );

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES),
    .IDLE_LEVEL  (1'b1)
  ) select_sync (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .async_in (bus.serialSelect_n),
    .level    (select_level),
    .rise     (select_rise),
    .fall     (select_fall)
  );

  // Only the rising shift-clock edge matters; the other outputs are sunk here.
  assign unused_sync = clock_level ^ clock_fall;

  // Data gets the same depth as the clock so a detected clock rise lines up
  // with the bit that was on the pin at that pin edge.
  logic [SYNC_STAGES-1:0] data_chain;
  logic                   data_bit;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      data_chain <= '0;
    end else begin
      data_chain <= {data_chain[SYNC_STAGES-2:0], bus.serialData};
    end
  end

  assign data_bit = data_chain[SYNC_STAGES-1];

  loader_state_t                   state;
  logic [BIT_WIDTH-1:0]            bit_count;
  logic [COUNT_WIDTH-1:0]          word_count;
  logic [DATA_WIDTH-1:0]           shift_reg;
  logic                            overflow;
  logic                            pending_start;
  logic [NUM_WORDS*DATA_WIDTH-1:0] shadow;
  logic [NUM_WORDS*DATA_WIDTH-1:0] data_out;
  logic                            frame_valid;
  logic                            busy_q;
  logic                            frame_error;
  logic                            overrun_q;

  logic [DATA_WIDTH-1:0] shift_next;
  logic                  word_done;
  logic                  word_write;

  always_comb begin
    shift_next = {shift_reg[DATA_WIDTH-2:0], data_bit};
    word_done  = (state == RECEIVE) && clock_rise && (bit_count == LAST_BIT);
    word_write = word_done && (word_count < FULL_COUNT);
  end

  // Shadow buffer: completed words land in slot wordCount. Deliberately not
  // reset; it is only ever exposed through a successful commit.
  always_ff @(posedge CLOCK_50) begin
    for (int k = 0; k < NUM_WORDS; k++) begin
      if (!reset && word_write && (word_count == COUNT_WIDTH'(k))) begin
        shadow[k*DATA_WIDTH +: DATA_WIDTH] <= shift_next;
      end
    end
  end

  // Receiver FSM with all outputs registered. frameTaken is applied first so
  // that a commit in the same cycle overrides it and keeps frameValid high.
  // A select fall seen during CHECK is remembered for one cycle and honoured
  // in IDLE if select is still low.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state         <= IDLE;
      bit_count     <= '0;
      word_count    <= '0;
      shift_reg     <= '0;
      overflow      <= 1'b0;
      pending_start <= 1'b0;
      data_out      <= '0;
      frame_valid   <= 1'b0;
      busy_q        <= 1'b0;
      frame_error   <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      if (bus.frameTaken) begin
        frame_valid <= 1'b0;
        overrun_q   <= 1'b0;
      end

      case (state)
        IDLE: begin
          pending_start <= 1'b0;
          if (select_fall || (pending_start && !select_level)) begin
            state       <= RECEIVE;
            busy_q      <= 1'b1;
            bit_count   <= '0;
            word_count  <= '0;
            shift_reg   <= '0;
            overflow    <= 1'b0;
            frame_error <= 1'b0;
          end
        end

        RECEIVE: begin
          if (clock_rise) begin
            shift_reg <= shift_next;
            if (bit_count == LAST_BIT) begin
              bit_count <= '0;
              if (word_count < FULL_COUNT) begin
                word_count <= word_count + 1'b1;
              end else begin
                overflow <= 1'b1;
              end
            end else begin
              bit_count <= bit_count + 1'b1;
            end
          end
          if (select_rise) begin
            state <= CHECK;
          end
        end

        CHECK: begin
          state         <= IDLE;
          busy_q        <= 1'b0;
          pending_start <= select_fall;
          if ((word_count == FULL_COUNT) && (bit_count == '0) && !overflow) begin
            data_out    <= shadow;
            frame_valid <= 1'b1;
            if (frame_valid && !bus.frameTaken) begin
              overrun_q <= 1'b1;
            end
          end else begin
            frame_error <= 1'b1;
          end
        end

        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dataOut    = data_out;
  assign bus.frameValid = frame_valid;
  assign bus.busy       = busy_q;
  assign bus.frameError = frame_error;
  assign bus.overrun    = overrun_q;
  assign bus.wordCount  = word_count;

endmodule

// File: doc/serial_frame_loader.md
SERIAL_FRAME_LOADER -- requirements
Module: serial_frame_loader

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 784, meaning number of data words per frame (the network input count).
REQ-002 SHALL have parameter DATA_WIDTH, default 16, meaning bits per word (Q8.8 network input).
REQ-003 SHALL have parameter SYNC_STAGES, default 2, meaning number of synchronizer flops on each asynchronous input (minimum 2).
REQ-004 SHALL have port CLOCK_50  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port serialClock  input  1  asynchronous external shift clock; data sampled on its rising edge.
REQ-007 SHALL have port serialData  input  1  asynchronous serial data, MSB of each word first.
REQ-008 SHALL have port serialSelect_n  input  1  asynchronous frame enable, active-low; low for the whole frame.
REQ-009 SHALL have port frameTaken  input  1  single-cycle consumer pulse acknowledging the current output frame.
REQ-010 SHALL have port dataOut  output  NUM_WORDS*DATA_WIDTH  committed frame; word k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-011 SHALL have port frameValid  output  1  committed frame available and not yet taken.
REQ-012 SHALL have port busy  output  1  frame reception in progress (FSM not IDLE).
REQ-013 SHALL have port frameError  output  1  last frame had wrong bit count; sticky until next frame start.
REQ-014 SHALL have port overrun  output  1  a frame was committed while frameValid was high; sticky until frameTaken.
REQ-015 SHALL have port wordCount  output  $clog2(NUM_WORDS+1)  words completed in current frame.

Function
REQ-016 SHALL pass serialClock and serialSelect_n each through SYNC_STAGES flops plus one history flop; edges detected by comparing last stage with history flop; serialData synchronized with equal depth.
REQ-017 SHALL implement FSM IDLE, RECEIVE, CHECK: IDLE->RECEIVE on detected select falling edge; RECEIVE->CHECK on detected select rising edge; CHECK->IDLE unconditionally after one cycle.
REQ-018 SHALL, on entering RECEIVE, clear bit counter, wordCount and frameError.
REQ-019 SHALL, in RECEIVE on each detected serialClock rising edge, shift synchronized data into a DATA_WIDTH shift register LSB-in (first bit ends as MSB).
REQ-020 SHALL, when the DATA_WIDTH-th bit of a word is shifted and wordCount < NUM_WORDS, write the word to shadow buffer slot wordCount and increment wordCount the same cycle; bit counter wraps to 0.
REQ-021 SHALL ignore words beyond NUM_WORDS (no write, wordCount saturates at NUM_WORDS) and record an overflow flag.
REQ-022 SHALL, in CHECK, commit if wordCount==NUM_WORDS, bit counter==0 and no overflow: dataOut<=shadow, frameValid<=1; otherwise frameError<=1 and dataOut/frameValid unchanged.
REQ-023 SHALL assert frameValid on the (SYNC_STAGES+2)th CLOCK_50 rising edge after serialSelect_n pin rise (4 at default).
REQ-024 SHALL set overrun on commit while frameValid already high; new frame overwrites dataOut (latest wins).
REQ-025 SHALL clear frameValid on frameTaken; commit and frameTaken in the same cycle leave frameValid=1 and do not set overrun.
REQ-026 SHALL ignore serialClock edges in IDLE and CHECK; select falling edge during CHECK is honoured on the next IDLE cycle only if still low (edge re-detected is not required; frame is then lost and counts as no frame).
REQ-027 SHALL hold dataOut stable at all times except the single commit cycle.
REQ-028 SHALL require serialClock high and low phases each >= SYNC_STAGES+1 CLOCK_50 periods; faster input is out of contract.

Reset
REQ-029 SHALL on reset set FSM IDLE, dataOut=0, frameValid=0, busy=0, frameError=0, overrun=0, wordCount=0, counters and synchronizer/history flops to idle levels (clock 0, select_n 1).
REQ-030 SHALL on reset mid-frame abandon the frame with no commit; shadow buffer contents need not be cleared.

Structure
REQ-031 SHALL place FSM state enum and default NUM_WORDS/DATA_WIDTH constants in shared package nn_io_pkg.
REQ-032 SHALL use one sub-module sync_edge_detect (SYNC_STAGES synchronizer, rise/fall pulses), instantiated for serialClock and serialSelect_n.

Verification (NUM_WORDS=4, DATA_WIDTH=8)
REQ-033 SHALL cover: frame of bytes 0x11,0x22,0x33,0x44 -> dataOut=0x44332211, frameValid=1 four cycles after select rise, frameError=0.
REQ-034 SHALL cover: frame of 31 bits -> frameError=1, frameValid=0, dataOut unchanged from previous value.
REQ-035 SHALL cover: frame of 5 bytes -> frameError=1, wordCount=4, no commit.
REQ-036 SHALL cover: two valid frames without frameTaken -> overrun=1, dataOut equals second frame; frameTaken then clears frameValid and overrun.
REQ-037 SHALL cover: reset after 2 bytes received -> all outputs zero, FSM IDLE; subsequent valid frame 0xA1,0xB2,0xC3,0xD4 commits 0xD4C3B2A1.
REQ-038 SHALL cover: frameTaken coincident with commit cycle -> frameValid stays 1, overrun stays 0.
